// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, ALU ops,
// opcode/funct values and datapath mux selects.
package mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ALU_WB   = 4'd10
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b1110;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_ADDU = 4'b0001;
  localparam logic [3:0] ALU_SUBU = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b0110;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS    = 2'b01;
  localparam logic [1:0] SRC_A_SHAMT = 2'b10;

  localparam logic [1:0] SRC_B_RT      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Only the signed add/sub ops raise an overflow exception.
  function automatic logic traps_on_ovf(input logic [3:0] alu_ctr);
    return (alu_ctr == ALU_ADD) || (alu_ctr == ALU_SUB);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in,
// control strobes and mux selects out.
interface mc_ctrl_fsm_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic [3:0] alu_ctr;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_op;
  logic       pc_we;
  logic       ir_we;
  logic       mem_re;
  logic       mem_we;
  logic       reg_we;
  logic [1:0] pc_src;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       ovf_exc;
  logic       illegal;

  modport master (
    input  op, funct, zero, overflow,
    output alu_ctr, alu_src_a, alu_src_b, ext_op, pc_we, ir_we, mem_re,
           mem_we, reg_we, pc_src, reg_dst, mem_to_reg, ovf_exc, illegal
  );

  modport slave (
    output op, funct, zero, overflow,
    input  alu_ctr, alu_src_a, alu_src_b, ext_op, pc_we, ir_we, mem_re,
           mem_we, reg_we, pc_src, reg_dst, mem_to_reg, ovf_exc, illegal
  );
endinterface

// File: rtl/mc_ctrl_fsm_alu_op_dec.sv
// ALU operation decoder: maps opcode/funct onto the ALU control code,
// immediate extension mode, shift-operand select and a bad-funct flag.
module alu_op_dec
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctr,
  output logic       ext_op,
  output logic       is_shift,
  output logic       bad_funct
);

  // Pure lookup; unknown opcodes fall back to addu with sign extension.
  always_comb begin
    alu_ctr   = ALU_ADDU;
    ext_op    = 1'b1;
    is_shift  = 1'b0;
    bad_funct = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_ctr = ALU_ADD;
          FN_ADDU: alu_ctr = ALU_ADDU;
          FN_SUB:  alu_ctr = ALU_SUB;
          FN_SUBU: alu_ctr = ALU_SUBU;
          FN_AND:  alu_ctr = ALU_AND;
          FN_OR:   alu_ctr = ALU_OR;
          FN_XOR:  alu_ctr = ALU_XOR;
          FN_SLL:  begin alu_ctr = ALU_SLL; is_shift = 1'b1; end
          FN_SRL:  begin alu_ctr = ALU_SRL; is_shift = 1'b1; end
          FN_SRA:  begin alu_ctr = ALU_SRA; is_shift = 1'b1; end
          default: bad_funct = 1'b1;
        endcase
      end
      OP_ADDI:  alu_ctr = ALU_ADD;
      OP_ADDIU: alu_ctr = ALU_ADDU;
      OP_ANDI:  begin alu_ctr = ALU_AND; ext_op = 1'b0; end
      OP_ORI:   begin alu_ctr = ALU_OR;  ext_op = 1'b0; end
      OP_XORI:  begin alu_ctr = ALU_XOR; ext_op = 1'b0; end
      OP_LUI:   begin alu_ctr = ALU_LUI; ext_op = 1'b0; end
      default:  alu_ctr = ALU_ADDU;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: state register plus combinational decode of
// strobes/selects from the current state and instruction fields.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mc_ctrl_fsm_if.master bus
);

  state_t     state;
  state_t     next_state;
  logic [3:0] dec_alu;
  logic       dec_ext;
  logic       dec_shift;
  logic       dec_bad;

  alu_op_dec u_dec (
    .op        (bus.op),
    .funct     (bus.funct),
    .alu_ctr   (dec_alu),
    .ext_op    (dec_ext),
    .is_shift  (dec_shift),
    .bad_funct (dec_bad)
  );

  // State register; reset drops straight back to FETCH without waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // Output and next-state decode; everything is forced idle while rst is high
  // so an abandoned instruction can never emit a write.
  always_comb begin
    next_state     = S_FETCH;
    bus.alu_ctr    = ALU_ADDU;
    bus.alu_src_a  = SRC_A_PC;
    bus.alu_src_b  = SRC_B_RT;
    bus.ext_op     = 1'b0;
    bus.pc_we      = 1'b0;
    bus.ir_we      = 1'b0;
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.reg_we     = 1'b0;
    bus.pc_src     = PC_SRC_ALU;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.ovf_exc    = 1'b0;
    bus.illegal    = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          bus.mem_re    = 1'b1;
          bus.ir_we     = 1'b1;
          bus.pc_we     = 1'b1;
          bus.alu_src_b = SRC_B_FOUR;
          next_state    = S_DECODE;
        end
        S_DECODE: begin
          bus.alu_src_b = SRC_B_IMM_SH2;
          bus.ext_op    = 1'b1;
          case (bus.op)
            OP_RTYPE:                                           next_state = S_EXEC_R;
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: next_state = S_EXEC_I;
            OP_LW, OP_SW:                                       next_state = S_MEM_ADDR;
            OP_BEQ:                                             next_state = S_BRANCH;
            OP_J:                                               next_state = S_JUMP;
            default: begin
              bus.illegal = 1'b1;
              next_state  = S_FETCH;
            end
          endcase
        end
        S_EXEC_R, S_EXEC_I: begin
          bus.alu_ctr   = dec_alu;
          bus.ext_op    = dec_ext;
          bus.alu_src_a = (state == S_EXEC_R && dec_shift) ? SRC_A_SHAMT : SRC_A_RS;
          bus.alu_src_b = (state == S_EXEC_R) ? SRC_B_RT : SRC_B_IMM;
          if (state == S_EXEC_R && dec_bad) begin
            bus.illegal = 1'b1;
            next_state  = S_FETCH;
          end else if (traps_on_ovf(dec_alu) && bus.overflow) begin
            bus.ovf_exc = 1'b1;
            next_state  = S_FETCH;
          end else begin
            next_state  = S_ALU_WB;
          end
        end
        S_ALU_WB: begin
          bus.reg_we  = 1'b1;
          bus.reg_dst = (bus.op == OP_RTYPE);
          next_state  = S_FETCH;
        end
        S_MEM_ADDR: begin
          bus.alu_src_a = SRC_A_RS;
          bus.alu_src_b = SRC_B_IMM;
          bus.ext_op    = 1'b1;
          next_state    = (bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          bus.mem_re = 1'b1;
          next_state = S_MEM_WB;
        end
        S_MEM_WB: begin
          bus.reg_we     = 1'b1;
          bus.mem_to_reg = 1'b1;
          next_state     = S_FETCH;
        end
        S_MEM_WR: begin
          bus.mem_we = 1'b1;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          bus.alu_src_a = SRC_A_RS;
          bus.alu_src_b = SRC_B_RT;
          bus.alu_ctr   = ALU_SUBU;
          bus.pc_src    = PC_SRC_ALUOUT;
          bus.pc_we     = bus.zero;
          next_state    = S_FETCH;
        end
        S_JUMP: begin
          bus.pc_src = PC_SRC_JUMP;
          bus.pc_we  = 1'b1;
          next_state = S_FETCH;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 op  in  6  instr[31:26], held stable by external IR outside FETCH.
REQ-004 funct  in  6  instr[5:0].
REQ-005 zero  in  1  ALU Zero flag, sampled combinationally in BRANCH.
REQ-006 overflow  in  1  ALU Overflow flag, sampled combinationally in EXEC.
REQ-007 alu_ctr  out  4  ALU op: 1110 add, 0100 sub, 0001 addu, 0101 subu, 0010 and, 0011 or, 0111 xor, 1010 sll, 1000 srl, 1001 sra, 0110 lui.
REQ-008 alu_src_a  out  2  00 PC, 01 rs, 10 shamt.
REQ-009 alu_src_b  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2.
REQ-010 ext_op  out  1  1 sign-extend imm, 0 zero-extend.
REQ-011 pc_we, ir_we, mem_re, mem_we, reg_we  out  1 each  write/read strobes.
REQ-012 pc_src  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
REQ-013 reg_dst  out  1  1 rd, 0 rt.
REQ-014 mem_to_reg  out  1  1 memory data, 0 ALUOut.
REQ-015 ovf_exc, illegal  out  1 each  one-cycle event pulses.

Function
REQ-016 States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, ALU_WB; 4-bit state register.
REQ-017 Outputs are combinational from state, op, funct, zero, overflow; unlisted strobes 0, unlisted selects 0.
REQ-018 FETCH: mem_re=1, ir_we=1, pc_we=1, pc_src=00, src_a=00, src_b=01, alu_ctr=0001; -> DECODE.
REQ-019 DECODE: src_a=00, src_b=11, ext_op=1, alu_ctr=0001 (branch target into ALUOut); next by op: 000000 -> EXEC_R; 001000/001001/001100/001101/001110/001111 -> EXEC_I; 100011/101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP; else illegal=1, -> FETCH.
REQ-020 EXEC_R funct map: 100000 add, 100001 addu, 100010 sub, 100011 subu, 100100 and, 100101 or, 100110 xor, src_a=01, src_b=00; 000000 sll, 000010 srl, 000011 sra with src_a=10, src_b=00; any other funct: illegal=1, -> FETCH, no write.
REQ-021 EXEC_I map: addi 1110 ext_op=1, addiu 0001 ext_op=1, andi 0010, ori 0011, xori 0111 ext_op=0, lui 0110; src_a=01, src_b=10.
REQ-022 EXEC with alu_ctr 1110 or 0100 and overflow=1: ovf_exc=1 that cycle, -> FETCH, ALU_WB skipped; otherwise -> ALU_WB.
REQ-023 ALU_WB: reg_we=1, mem_to_reg=0, reg_dst=1 if op=000000 else 0; -> FETCH.
REQ-024 MEM_ADDR: src_a=01, src_b=10, ext_op=1, alu_ctr=0001; lw -> MEM_RD, sw -> MEM_WR.
REQ-025 MEM_RD: mem_re=1 -> MEM_WB; MEM_WB: reg_we=1, mem_to_reg=1, reg_dst=0 -> FETCH; MEM_WR: mem_we=1 -> FETCH.
REQ-026 BRANCH: src_a=01, src_b=00, alu_ctr=0101, pc_src=01, pc_we=zero; -> FETCH.
REQ-027 JUMP: pc_src=10, pc_we=1; -> FETCH.
REQ-028 Latency per instruction: R/I-ALU 4, lw 5, sw 4, beq 3, j 3 cycles; overflowing add/sub 3; illegal 2.

Reset
REQ-029 rst=1 forces state FETCH immediately; while rst=1 pc_we, ir_we, mem_re, mem_we, reg_we, ovf_exc, illegal = 0, selects 00, alu_ctr=0001.
REQ-030 Reset mid-instruction abandons it with no write strobe; first cycle after release is FETCH.

Structure
REQ-031 Shared package holds ALU op codes, opcode/funct constants, state encodings, mux select encodings.
REQ-032 One sub-module alu_op_dec: combinational op/funct -> alu_ctr, ext_op, illegal-funct flag.

Verification
REQ-033 add with overflow=1 in EXEC_R: ovf_exc pulse, reg_we never 1, FETCH 3 cycles after prior FETCH.
REQ-034 lw op=100011: states FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; reg_we=1, mem_to_reg=1 only in cycle 5.
REQ-035 beq zero=1 -> pc_we=1 pc_src=01 in cycle 3; zero=0 -> pc_we=0.
REQ-036 sra funct=000011: alu_ctr=1001, src_a=10; ori: alu_ctr=0011, ext_op=0.
REQ-037 op=111111: illegal pulse in DECODE, next FETCH; funct=001000 in EXEC_R: illegal, no reg_we.
REQ-038 rst asserted in MEM_WR asynchronously: mem_we drops same cycle, state FETCH.
